i_execute: RTL and testbench
============================

I_EXECUTE -- requirements
Module: i_execute

Interface
REQ-001 Parameter: DW, default 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  hold the EX/MEM register contents.
REQ-005 flush  in  1  load a bubble into the EX/MEM register.
REQ-006 wb_ctl  in  2  ID/EX writeback control {regwrite, memtoreg}, passed through.
REQ-007 m_ctl  in  3  ID/EX memory control {branch, memread, memwrite}.
REQ-008 regdst, alusrc  in  1 each  destination select and ALU B-operand select.
REQ-009 aluop  in  2  ALU operation class from decode.
REQ-010 npc, rdata1, rdata2, s_extend  in  32 each  next PC, register operands and sign-extended immediate.
REQ-011 instr_2016, instr_1511  in  5 each  rt and rd fields.
REQ-012 wb_ctlout_pipe  out  2; branch, memread, memwrite  out  1 each; zero  out  1.
REQ-013 add_result, alu_result, rdata2out_pipe  out  32 each; five_bit_muxout  out  5; all are registered EX/MEM outputs.

Function
REQ-014 The ALU B operand SHALL be s_extend when alusrc=1, else rdata2.
REQ-015 The destination register SHALL be instr_1511 when regdst=1, else instr_2016.
REQ-016 ALU control: aluop 00 -> ADD; 01 -> SUB; 10 -> decode funct = s_extend[5:0].
REQ-017 Funct decode: 0x20 -> ADD, 0x22 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x2A -> SLT, 0x27 -> NOR.
REQ-018 Any other funct, or aluop 11, SHALL produce an ALU result of 0 (and therefore zero=1).
REQ-019 ADD and SUB SHALL wrap modulo 2^32 and produce no overflow flag or trap.
REQ-020 SLT SHALL be a signed two's-complement compare giving 32'h1 or 32'h0.
REQ-021 The branch target SHALL be npc + (s_extend << 2), truncated to 32 bits (wraps).
REQ-022 Combinational zero SHALL equal (ALU result == 0).
REQ-023 EX/MEM register: on each rising clk with flush=0 and stall=0, it SHALL capture wb_ctl, m_ctl, branch target, zero, ALU result, rdata2 and destination register; latency is 1 cycle.
REQ-024 When stall=1 and flush=0, all outputs SHALL hold their values.
REQ-025 When flush=1, wb_ctlout_pipe, branch, memread, memwrite and zero SHALL load 0, and all data outputs SHALL load 0.
REQ-026 Flush SHALL take priority over stall when both are asserted.
REQ-027 Outputs SHALL depend only on registered state; there is no combinational input-to-output path.

Reset
REQ-028 When rst_n=0, all outputs SHALL go to 0 immediately, independent of clk.
REQ-029 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-030 On the first rising edge after rst_n deasserts, the register SHALL capture normally.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight instruction, with no partial update.

Structure
REQ-032 A shared package SHALL hold the 4-bit ALU control codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, ZERO 1111), the funct constants and the aluop encodings.
REQ-033 The block SHALL contain one sub-module, alu_ctl_alu, holding the ALU control decode and the ALU (combinational); muxes, the adder and the EX/MEM register stay in i_execute.

Verification
REQ-034 R-type add: aluop=10, funct=0x20, rdata1=5, rdata2=7, regdst=1, rd=3 -> next cycle alu_result=12, zero=0, five_bit_muxout=3.
REQ-035 beq equal: aluop=01, rdata1=rdata2=0x1234, npc=0x100, s_extend=4, m_ctl=100 -> alu_result=0, zero=1, branch=1, add_result=0x110.
REQ-036 SLT signed: rdata1=0xFFFFFFFF, rdata2=1, funct=0x2A -> alu_result=1; operands swapped -> 0.
REQ-037 lw with negative offset: aluop=00, alusrc=1, rdata1=0x40, s_extend=0xFFFFFFFC, regdst=0, rt=9 -> alu_result=0x3C, five_bit_muxout=9.
REQ-038 Stall then flush: load an ADD, assert stall 2 cycles -> outputs unchanged; assert flush with stall=1 -> all outputs 0 next cycle.
REQ-039 Reset mid-stream: drop rst_n between clock edges while outputs are nonzero -> all outputs 0 before the next edge; illegal funct 0x3F -> alu_result=0, zero=1.

Source files
------------

// File: rtl/i_execute_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i_execute_pkg
// Description : Shared ALU control codes, funct/aluop encodings and EX/MEM
//               register layout for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package i_execute_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_ZERO = 4'b1111
    } alu_ctl_e;

    localparam logic [5:0] C_FUNCT_ADD = 6'h20;
    localparam logic [5:0] C_FUNCT_SUB = 6'h22;
    localparam logic [5:0] C_FUNCT_AND = 6'h24;
    localparam logic [5:0] C_FUNCT_OR  = 6'h25;
    localparam logic [5:0] C_FUNCT_NOR = 6'h27;
    localparam logic [5:0] C_FUNCT_SLT = 6'h2A;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] C_ALUOP_NONE  = 2'b11;

    typedef struct packed {
        logic [1:0]  wb_ctl;
        logic [2:0]  m_ctl;
        logic [31:0] add_result;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] rdata2;
        logic [4:0]  dst;
    } exmem_t;

    // Unlisted funct values fall through to ALU_ZERO so they yield a zero result.
    function automatic alu_ctl_e decode_funct(input logic [5:0] funct);
        case (funct)
            C_FUNCT_ADD: return ALU_ADD;
            C_FUNCT_SUB: return ALU_SUB;
            C_FUNCT_AND: return ALU_AND;
            C_FUNCT_OR:  return ALU_OR;
            C_FUNCT_NOR: return ALU_NOR;
            C_FUNCT_SLT: return ALU_SLT;
            default:     return ALU_ZERO;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/i_execute_alu_ctl_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctl_alu
// Description : Combinational ALU control decode plus the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctl_alu
    import i_execute_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    aluop,
    input  logic [5:0]    funct,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero
);

    alu_ctl_e      w_ctl;
    logic [DW-1:0] w_result;

    always_comb begin
        w_ctl = ALU_ZERO;
        case (aluop)
            C_ALUOP_ADD:   w_ctl = ALU_ADD;
            C_ALUOP_SUB:   w_ctl = ALU_SUB;
            C_ALUOP_RTYPE: w_ctl = decode_funct(funct);
            default:       w_ctl = ALU_ZERO;
        endcase
    end

    always_comb begin
        w_result = '0;
        case (w_ctl)
            ALU_AND: w_result = a & b;
            ALU_OR:  w_result = a | b;
            ALU_ADD: w_result = a + b;
            ALU_SUB: w_result = a - b;
            ALU_SLT: w_result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: w_result = ~(a | b);
            default: w_result = '0;
        endcase
    end

    assign result = w_result;
    assign zero   = (w_result == '0);

endmodule
`default_nettype wire

// File: rtl/i_execute.sv
`default_nettype none
// ============================================================================
// Module      : i_execute
// Description : Pipeline execute stage: operand/destination muxes, branch
//               target adder, ALU and the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module i_execute
    import i_execute_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [1:0]    wb_ctl,
    input  logic [2:0]    m_ctl,
    input  logic          regdst,
    input  logic          alusrc,
    input  logic [1:0]    aluop,
    input  logic [DW-1:0] npc,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    input  logic [DW-1:0] s_extend,
    input  logic [4:0]    instr_2016,
    input  logic [4:0]    instr_1511,
    output logic [1:0]    wb_ctlout_pipe,
    output logic          branch,
    output logic          memread,
    output logic          memwrite,
    output logic          zero,
    output logic [DW-1:0] add_result,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] rdata2out_pipe,
    output logic [4:0]    five_bit_muxout
);

    logic [DW-1:0] w_alu_b;
    logic [4:0]    w_dst;
    logic [DW-1:0] w_branch_target;
    logic [DW-1:0] w_alu_result;
    logic          w_zero;
    exmem_t        r_exmem;

    assign w_alu_b         = alusrc ? s_extend : rdata2;
    assign w_dst           = regdst ? instr_1511 : instr_2016;
    assign w_branch_target = npc + (s_extend << 2);

    alu_ctl_alu #(
        .DW (DW)
    ) u_alu_ctl_alu (
        .aluop  (aluop),
        .funct  (s_extend[5:0]),
        .a      (rdata1),
        .b      (w_alu_b),
        .result (w_alu_result),
        .zero   (w_zero)
    );

    // Flush outranks stall so a squashed instruction never lingers in EX/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else if (flush) begin
            r_exmem <= '0;
        end else if (!stall) begin
            r_exmem.wb_ctl     <= wb_ctl;
            r_exmem.m_ctl      <= m_ctl;
            r_exmem.add_result <= w_branch_target;
            r_exmem.zero       <= w_zero;
            r_exmem.alu_result <= w_alu_result;
            r_exmem.rdata2     <= rdata2;
            r_exmem.dst        <= w_dst;
        end
    end

    assign wb_ctlout_pipe  = r_exmem.wb_ctl;
    assign branch          = r_exmem.m_ctl[2];
    assign memread         = r_exmem.m_ctl[1];
    assign memwrite        = r_exmem.m_ctl[0];
    assign zero            = r_exmem.zero;
    assign add_result      = r_exmem.add_result;
    assign alu_result      = r_exmem.alu_result;
    assign rdata2out_pipe  = r_exmem.rdata2;
    assign five_bit_muxout = r_exmem.dst;

endmodule
`default_nettype wire

// File: tb/tb_i_execute.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_execute
// Description : Self-checking bench for i_execute: directed vector table,
//               stall/flush/reset sequences and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_execute;

    typedef struct {
        logic [1:0]  aluop;
        logic        alusrc;
        logic        regdst;
        logic [31:0] npc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] e_alu;
        logic [31:0] e_add;
        logic        e_zero;
        logic [4:0]  e_dst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, regdst, alusrc;
    logic [1:0]  wb_ctl, aluop;
    logic [2:0]  m_ctl;
    logic [31:0] npc, rdata1, rdata2, s_extend;
    logic [4:0]  instr_2016, instr_1511;
    logic [1:0]  wb_ctlout_pipe;
    logic        branch, memread, memwrite, zero;
    logic [31:0] add_result, alu_result, rdata2out_pipe;
    logic [4:0]  five_bit_muxout;

    int errors = 0;
    int checks = 0;
    vec_t tbl [10];

    i_execute #(.DW(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .wb_ctl          (wb_ctl),
        .m_ctl           (m_ctl),
        .regdst          (regdst),
        .alusrc          (alusrc),
        .aluop           (aluop),
        .npc             (npc),
        .rdata1          (rdata1),
        .rdata2          (rdata2),
        .s_extend        (s_extend),
        .instr_2016      (instr_2016),
        .instr_1511      (instr_1511),
        .wb_ctlout_pipe  (wb_ctlout_pipe),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .add_result      (add_result),
        .alu_result      (alu_result),
        .rdata2out_pipe  (rdata2out_pipe),
        .five_bit_muxout (five_bit_muxout)
    );

    always #5 clk = ~clk;

    // Reference ALU written straight from the operation table.
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return 32'h0;
        case (fn)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h27:   return ~(a | b);
            6'h2A:   return (signed'(a) < signed'(b)) ? 32'h1 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] wb, input logic [2:0] m,
                           input logic [31:0] add, input logic z, input logic [31:0] alu,
                           input logic [31:0] r2, input logic [4:0] dst);
        chk({tag, ".wb"},   {30'd0, wb_ctlout_pipe}, {30'd0, wb});
        chk({tag, ".mctl"}, {29'd0, branch, memread, memwrite}, {29'd0, m});
        chk({tag, ".add"},  add_result, add);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, ".alu"},  alu_result, alu);
        chk({tag, ".rd2"},  rdata2out_pipe, r2);
        chk({tag, ".dst"},  {27'd0, five_bit_muxout}, {27'd0, dst});
    endtask

    task automatic drive(input vec_t v);
        aluop = v.aluop;   alusrc = v.alusrc;   regdst = v.regdst;
        npc = v.npc;       rdata1 = v.r1;       rdata2 = v.r2;
        s_extend = v.sext; instr_2016 = v.rt;   instr_1511 = v.rd;
        m_ctl = v.m;       wb_ctl = v.wb;
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk_all(tag, v.wb, v.m, v.e_add, v.e_zero, v.e_alu, v.r2, v.e_dst);
    endtask

    initial begin
        //          aluop  src   rdst  npc          r1           r2           sext         rt     rd     m       wb     e_alu        e_add        z     dst
        tbl[0] = '{2'b10, 1'b0, 1'b1, 32'h0,       32'd5,       32'd7,       32'h20,      5'd0,  5'd3,  3'b000, 2'b10, 32'd12,      32'h80,      1'b0, 5'd3};
        tbl[1] = '{2'b01, 1'b0, 1'b0, 32'h100,     32'h1234,    32'h1234,    32'd4,       5'd0,  5'd0,  3'b100, 2'b00, 32'h0,       32'h110,     1'b1, 5'd0};
        tbl[2] = '{2'b10, 1'b0, 1'b1, 32'h0,       32'hFFFFFFFF,32'd1,       32'h2A,      5'd0,  5'd4,  3'b000, 2'b10, 32'h1,       32'hA8,      1'b0, 5'd4};
        tbl[3] = '{2'b10, 1'b0, 1'b1, 32'h0,       32'd1,       32'hFFFFFFFF,32'h2A,      5'd0,  5'd4,  3'b000, 2'b10, 32'h0,       32'hA8,      1'b1, 5'd4};
        tbl[4] = '{2'b00, 1'b1, 1'b0, 32'h200,     32'h40,      32'h55,      32'hFFFFFFFC,5'd9,  5'd1,  3'b010, 2'b11, 32'h3C,      32'h1F0,     1'b0, 5'd9};
        tbl[5] = '{2'b10, 1'b0, 1'b1, 32'h0,       32'd5,       32'd7,       32'h3F,      5'd0,  5'd6,  3'b000, 2'b10, 32'h0,       32'hFC,      1'b1, 5'd6};
        tbl[6] = '{2'b11, 1'b0, 1'b1, 32'h0,       32'd3,       32'd4,       32'h20,      5'd2,  5'd7,  3'b001, 2'b01, 32'h0,       32'h80,      1'b1, 5'd7};
        tbl[7] = '{2'b01, 1'b0, 1'b0, 32'h0,       32'd0,       32'd1,       32'd0,       5'd8,  5'd2,  3'b000, 2'b00, 32'hFFFFFFFF,32'h0,       1'b0, 5'd8};
        tbl[8] = '{2'b10, 1'b0, 1'b1, 32'h10,      32'hF0F0,    32'hFF00,    32'h24,      5'd0,  5'd12, 3'b000, 2'b10, 32'hF000,    32'hA0,      1'b0, 5'd12};
        tbl[9] = '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFC,32'h0,       32'h0,       32'h27,      5'd0,  5'd31, 3'b000, 2'b10, 32'hFFFFFFFF,32'h98,      1'b0, 5'd31};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(tbl[0]);
        #2;
        chk_all("reset", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Stall for two cycles with changing inputs, then flush under stall.
        @(negedge clk); drive(tbl[0]);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); stall = 1'b1; drive(tbl[7 + k]);
            @(posedge clk); #1;
            chk_vec($sformatf("stall%0d", k), tbl[0]);
        end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        chk_all("flush_stall", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk); flush = 1'b0; stall = 1'b0;

        // Asynchronous reset between edges, then normal capture after release.
        drive(tbl[4]);
        @(posedge clk); #1;
        chk_vec("pre_rst", tbl[4]);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk); stall = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk_all("rst_hold", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk); rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk_vec("post_rst", tbl[4]);

        // Randomized operations against the reference model.
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            logic [5:0] fn_pool [7];
            logic [31:0] b_op;
            fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
            v.aluop  = 2'($urandom_range(0, 3));
            v.alusrc = 1'($urandom);
            v.regdst = 1'($urandom);
            v.npc    = $urandom;
            v.r1     = $urandom;
            v.r2     = ($urandom_range(0, 7) == 0) ? v.r1 : $urandom;
            v.sext   = $urandom;
            if ($urandom_range(0, 3) != 0) v.sext[5:0] = fn_pool[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) v.r1 = {~v.r1[31], v.r1[30:0]};
            v.rt     = 5'($urandom);
            v.rd     = 5'($urandom);
            v.m      = 3'($urandom);
            v.wb     = 2'($urandom);
            b_op     = v.alusrc ? v.sext : v.r2;
            v.e_alu  = ref_alu(v.aluop, v.sext[5:0], v.r1, b_op);
            v.e_zero = (v.e_alu == 32'h0);
            v.e_add  = v.npc + v.sext * 4;
            v.e_dst  = v.regdst ? v.rd : v.rt;
            @(negedge clk);
            drive(v);
            @(posedge clk);
            #1;
            chk_vec($sformatf("rand%0d", n), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
